// File: rtl/reg_c_seq.sv
// rtl/reg_c_seq.sv - frame sequencer for the 15-bit reg_c shift stage
//
// Accepts one N-bit word per frame, clears reg_c, drives shift for exactly
// N+K cycles, cross-checks reg_c's shift count and hands the final 15-bit
// reg_c value downstream.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    upstream word handshake; in_ready is high only in IDLE
//   in_data[N-1:0]       upstream word, sampled on the accept edge
//   c_clr                registered one-cycle clear pulse to reg_c
//   c_shift              registered shift enable to reg_c
//   c_data[N-1:0]        registered copy of the accepted word (reg_c data_in)
//   c_count[10:0]        reg_c shift count, checked in CHECK
//   c_value[14:0]        reg_c register contents, captured in CHECK
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   out_data[14:0]       captured reg_c value
//   out_err              count mismatch flag, qualified by out_valid
//   busy                 high in any state other than IDLE
module reg_c_seq #(
  parameter int N = 64,
  parameter int K = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         c_clr,
  output logic         c_shift,
  output logic [N-1:0] c_data,
  input  logic [10:0]  c_count,
  input  logic [14:0]  c_value,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [14:0]  out_data,
  output logic         out_err,
  output logic         busy
);

  localparam int          TOTAL   = N + K;
  localparam logic [10:0] TOTAL_C = 11'(TOTAL);
  localparam logic [10:0] LAST_C  = 11'(TOTAL - 1);

  // The shift counter and reg_c's count are both 11 bits wide.
  generate
    if (TOTAL > 2047 || N < 1 || K < 0) begin : g_bad_params
      $error("reg_c_seq: N+K must be in 1..2047 with N>=1, K>=0");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [N-1:0] c_data_q, c_data_d;
  logic [14:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;
  logic        c_clr_q, c_clr_d;
  logic        c_shift_q, c_shift_d;

  logic accept;
  logic last_shift;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_shift = (cnt_q == LAST_C);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // cnt_q counts completed shift cycles; the cycle seeing TOTAL-1 is
        // the TOTAL-th one.
        if (last_shift) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // in_valid is deliberately not looked at here; a waiting word is
        // taken in the following IDLE cycle.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM output decode (handshake and status outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    c_data_d   = c_data_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;

    if (accept) begin
      c_data_d = in_data;
    end

    if (state_q == S_CLEAR) begin
      cnt_d = 11'd0;
    end else if (state_q == S_SHIFT) begin
      cnt_d = cnt_q + 11'd1;
    end

    // reg_c's value and count are final during CHECK.
    if (state_q == S_CHECK) begin
      out_data_d = c_value;
      out_err_d  = (c_count != TOTAL_C);
    end
  end

  // reg_c control strobes are registered from the next state so they line up
  // exactly with the CLEAR / SHIFT cycles and cannot glitch.
  assign c_clr_d   = (state_d == S_CLEAR);
  assign c_shift_d = (state_d == S_SHIFT);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_data_q   <= '0;
      cnt_q      <= 11'd0;
      out_data_q <= 15'd0;
      out_err_q  <= 1'b0;
      c_clr_q    <= 1'b0;
      c_shift_q  <= 1'b0;
    end else begin
      c_data_q   <= c_data_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      c_clr_q    <= c_clr_d;
      c_shift_q  <= c_shift_d;
    end
  end

  assign c_data   = c_data_q;
  assign c_clr    = c_clr_q;
  assign c_shift  = c_shift_q;
  assign out_data = out_data_q;
  assign out_err  = out_err_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_clr_shift_excl: assert property (
    @(posedge clk) disable iff (rst) !(c_clr_q && c_shift_q)
  );

  a_shift_only_in_shift: assert property (
    @(posedge clk) disable iff (rst) c_shift_q |-> (state_q == S_SHIFT)
  );

  a_clr_only_in_clear: assert property (
    @(posedge clk) disable iff (rst) c_clr_q |-> (state_q == S_CLEAR)
  );

endmodule

// File: doc/reg_c_seq.md
# reg_c_seq

Frame sequencer for the 15-bit reg_c shift stage. It accepts one N-bit data word per frame over a valid/ready handshake and holds it stable on reg_c's data input. It clears reg_c, drives `shift` for exactly N+K cycles, cross-checks reg_c's shift count, and returns the final 15-bit register value downstream over a second valid/ready handshake. It sits directly upstream of reg_c (drives `shift`, `data_in`, clear) and also consumes reg_c's `count`/`data_out`.

## Interface
- N, 64, data word width; bits shifted MSB first.
- K, 40, zero-bit tail shifts after the N data bits; N+K must be ≤ 2047 (11-bit count), otherwise elaboration error.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  N  upstream word.
- c_clr  out  1  registered clear pulse to reg_c's rst input.
- c_shift  out  1  registered shift enable to reg_c.
- c_data  out  N  registered copy of the accepted word, to reg_c data_in.
- c_count  in  11  reg_c shift count.
- c_value  in  15  reg_c register contents.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  15  captured reg_c value.
- out_err  out  1  count mismatch flag, qualified by out_valid.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, SHIFT, CHECK, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: c_data<=in_data, go to CLEAR. Otherwise stay.
- CLEAR: c_clr=1 for exactly one cycle, then SHIFT. Shift counter loads 0.
- SHIFT: c_shift=1 every cycle. Internal 11-bit counter increments per cycle. Leave after the (N+K)-th shift cycle, then go to CHECK.
- CHECK: one cycle. out_data<=c_value. out_err<=(c_count != N+K). Then go to DONE.
- DONE: out_valid=1, with out_data/out_err held stable. On out_ready go to IDLE, where out_valid drops. Outputs are not cleared on exit; they keep their last values.
- c_data stays constant from the accept edge until the next accept. in_data changes outside the accept edge are ignored.
- c_shift and c_clr are never both high. c_shift is never high outside SHIFT.
- No overlap: a new word is accepted only after the DONE handshake, so the earliest accept is one cycle later, in IDLE.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, c_clr=0, c_shift=0, c_data=0, out_valid=0, out_data=0, out_err=0, busy=0, shift counter=0.
- Reset mid-frame (any state) aborts immediately to IDLE. There is no partial result, and out_valid is never asserted for the aborted frame.
- Accept at edge E0 (IDLE to CLEAR).
- c_clr is high during cycle E0–E1.
- c_shift is high during cycles E1…E(N+K+1). These are exactly N+K rising edges with shift=1, at E2…E(N+K+1).
- CHECK is cycle E(N+K+1)–E(N+K+2); c_value and c_count are final here.
- out_valid rises after E(N+K+2), i.e. N+K+2 cycles after accept.
- Result handshake completes at the first edge with out_valid&&out_ready. in_ready rises after that edge.
- Minimum frame period is N+K+4 cycles, achieved when out_ready is held high.
- Backpressure: out_valid stays high with a stable payload for any number of cycles until out_ready.
- Simultaneous in_valid and out_ready in DONE: only the result handshake occurs. in_valid is serviced in the following IDLE cycle.

## Test plan
- Reset then idle, in_valid=0 for 20 cycles → in_ready=1, busy=0, c_shift=0, c_clr=0, out_valid=0 throughout.
- N=64, K=40, in_data=64'h8000_0000_0000_0000, out_ready=1 → c_clr high 1 cycle, c_shift high exactly 104 cycles, out_valid high 106 cycles after accept, out_err=0, out_data equal to the reg_c golden model value.
- Same frame with out_ready held low 50 cycles after out_valid → out_valid and out_data stable for all 50 cycles, in_ready=0, handshake then returns to IDLE.
- Back-to-back frames 64'hFFFF_FFFF_FFFF_FFFF then 64'h0 with continuous in_valid/out_ready → second accept exactly 108 cycles after the first, and the second result is 15'h0000.
- Bench forces c_count to 103 during CHECK → out_err=1 with out_valid, FSM still returns to IDLE after out_ready.
- Assert rst at shift cycle 30 of a frame → all outputs at reset values asynchronously, no out_valid for that frame, next frame after rst release produces a correct result.
